// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU feeding a register bank: single-cycle logic/arithmetic ops,
// and a WIDTH-step shift-add multiplier. The result is registered and announced by a done/Habilita pulse.
module ula_multiciclo #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] E,
  output logic             Habilita,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_DONE} state_t;

  state_t             state_r;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   e_r;
  logic               z_r, n_r, c_r, v_r;
  logic               done_r, hab_r, busy_r;

  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH:0]     shl_s;
  logic [WIDTH-1:0]   res_s;
  logic               c_s, v_s;

  // Bit WIDTH of each extended result is the carry, borrow, or last bit shifted out.
  assign sum_s  = {1'b0, a_r} + {1'b0, b_r};
  assign diff_s = {1'b0, a_r} - {1'b0, b_r};
  assign shl_s  = {1'b0, a_r} << b_r[3:0];

  // Single-cycle operation result and carry/overflow, from the latched operands
  always_comb begin
    res_s = {WIDTH{1'b0}};
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (op_r)
      OP_ADD: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        res_s = diff_s[WIDTH-1:0];
        c_s   = diff_s[WIDTH];
        v_s   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_AND:  res_s = a_r & b_r;
      OP_OR:   res_s = a_r | b_r;
      OP_XOR:  res_s = a_r ^ b_r;
      OP_NOT:  res_s = ~a_r;
      OP_SHL: begin
        res_s = shl_s[WIDTH-1:0];
        c_s   = shl_s[WIDTH];
      end
      default: begin
        res_s = {WIDTH{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
      end
    endcase
  end

  // Control FSM, operand latch, shift-add multiplier and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      op_r     <= 3'b000;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      e_r      <= {WIDTH{1'b0}};
      z_r      <= 1'b0;
      n_r      <= 1'b0;
      c_r      <= 1'b0;
      v_r      <= 1'b0;
      done_r   <= 1'b0;
      hab_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      hab_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r     <= op;
            a_r      <= A;
            b_r      <= B;
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, A};
            mplier_r <= B;
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= (op == OP_MUL) ? ST_MUL : ST_EXEC;
          end else begin
            busy_r   <= 1'b0;
          end
        end
        ST_EXEC: begin
          e_r     <= res_s;
          z_r     <= (res_s == {WIDTH{1'b0}});
          n_r     <= res_s[WIDTH-1];
          c_r     <= c_s;
          v_r     <= v_s;
          done_r  <= 1'b1;
          hab_r   <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_MUL: begin
          // WIDTH partial-product steps, then one cycle to publish the product
          if (cnt_r == CNT_LAST) begin
            e_r     <= acc_r[WIDTH-1:0];
            z_r     <= (acc_r[WIDTH-1:0] == {WIDTH{1'b0}});
            n_r     <= acc_r[WIDTH-1];
            c_r     <= |acc_r[2*WIDTH-1:WIDTH];
            v_r     <= 1'b0;
            done_r  <= 1'b1;
            hab_r   <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            if (mplier_r[0]) begin
              acc_r <= acc_r + mcand_r;
            end
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign E        = e_r;
  assign flag_z   = z_r;
  assign flag_n   = n_r;
  assign flag_c   = c_r;
  assign flag_v   = v_r;
  assign done     = done_r;
  assign Habilita = hab_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed self-checking bench for ula_multiciclo (WIDTH=16): every op, flags,
// EXEC/MUL latency, start ignored while busy, asynchronous reset abort.
module tb_ula_multiciclo;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [15:0] A, B;
  logic [15:0] E;
  logic        Habilita, busy, done;
  logic        flag_z, flag_n, flag_c, flag_v;

  int checks = 0;
  int errors = 0;

  ula_multiciclo #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .E(E), .Habilita(Habilita), .busy(busy), .done(done),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation; lat = edges from start edge to the done edge.
  // inject_at > 0 pulses a competing ADD start that many edges into the operation.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b, input int lat, input int inject_at,
                        input logic [15:0] exp_e, input logic [3:0] exp_znvc);
    logic early;
    early = 1'b0;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (i < lat) begin
        if (done !== 1'b0 || Habilita !== 1'b0 || busy !== 1'b1) early = 1'b1;
        if (i == inject_at) begin
          start = 1'b1; op = 3'b000; A = 16'h0001; B = 16'h0001;
        end
      end
    end
    chk({tag, "_early"}, {31'd0, early}, 32'd0);
    chk({tag, "_pulse"}, {29'd0, done, Habilita, busy}, 32'd7);
    chk({tag, "_E"}, {16'd0, E}, {16'd0, exp_e});
    chk({tag, "_zncv"}, {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, exp_znvc});
    @(posedge clock); #1;
    chk({tag, "_after"}, {29'd0, done, Habilita, busy}, 32'd0);
  endtask

  initial begin
    logic seen;
    // Reset with start held high: must be ignored
    reset = 1'b1; start = 1'b1; op = 3'b000; A = 16'h1111; B = 16'h0001;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_E", {16'd0, E}, 32'd0);
    chk("rst_ctl", {25'd0, done, Habilita, busy, flag_z, flag_n, flag_c, flag_v}, 32'd0);
    start = 1'b0;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_idle", {31'd0, busy}, 32'd0);

    // flag order passed as {z,n,c,v}
    run_op("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 1, 0, 16'h8000, 4'b0101);
    run_op("add_cry", 3'b000, 16'hFFFF, 16'h0002, 1, 0, 16'h0001, 4'b0010);
    run_op("sub_brw", 3'b001, 16'h0003, 16'h0005, 1, 0, 16'hFFFE, 4'b0110);
    run_op("sub_eq",  3'b001, 16'h1234, 16'h1234, 1, 0, 16'h0000, 4'b1000);
    run_op("sub_ovf", 3'b001, 16'h8000, 16'h0001, 1, 0, 16'h7FFF, 4'b0001);
    run_op("and",     3'b010, 16'hF0F0, 16'h3C3C, 1, 0, 16'h3030, 4'b0000);
    run_op("or",      3'b011, 16'h0F00, 16'h00F0, 1, 0, 16'h0FF0, 4'b0000);
    run_op("xor",     3'b100, 16'hFFFF, 16'h0F0F, 1, 0, 16'hF0F0, 4'b0100);
    run_op("not",     3'b101, 16'h00FF, 16'h1234, 1, 0, 16'hFF00, 4'b0100);
    run_op("shl1",    3'b110, 16'h8001, 16'h0001, 1, 0, 16'h0002, 4'b0010);
    run_op("shl0",    3'b110, 16'h8001, 16'h0000, 1, 0, 16'h8001, 4'b0100);
    run_op("shl_msk", 3'b110, 16'h0003, 16'h0014, 1, 0, 16'h0030, 4'b0000);
    run_op("mul",     3'b111, 16'h0123, 16'h0010, 17, 0, 16'h1230, 4'b0000);
    run_op("mul_hi",  3'b111, 16'h1000, 16'h0010, 17, 0, 16'h0000, 4'b1010);

    // Result and flags hold while idle
    repeat (3) @(posedge clock);
    #1;
    chk("hold_E", {16'd0, E}, 32'd0);
    chk("hold_f", {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, 4'b1010});

    run_op("mul_ign", 3'b111, 16'h00FF, 16'h0101, 17, 5, 16'hFFFF, 4'b0100);

    // Asynchronous reset during the 8th MUL cycle aborts without a pulse
    start = 1'b1; op = 3'b111; A = 16'h0003; B = 16'h0005;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_E", {16'd0, E}, 32'd0);
    chk("arst_ctl", {25'd0, done, Habilita, busy, flag_z, flag_n, flag_c, flag_v}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (done !== 1'b0 || Habilita !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("arst_quiet", {31'd0, seen}, 32'd0);
    run_op("add_post", 3'b000, 16'h0002, 16'h0003, 1, 0, 16'h0005, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
